mba_nch: RTL and testbench

Parametrised N-channel memory bus arbiter, successor to the two-channel L2/DSC arbiter in `src/mcu`. It sits between the memory-side requesters (L2, DSC and further masters) and the shared external data bus. It owns the bus direction (`o_data_bus_rw`) and enable (`o_data_bus_enable`), and inserts a bounded turnaround between owners or directions. Compared to its predecessor it adds:
- per-channel request recording,
- selectable fixed-priority or round-robin arbitration,
- a starvation limit on burst ownership.

---
 rtl/mba_pkg.sv | 24 ++
 rtl/mba_pick.sv | 40 ++++
 rtl/mba_nch.sv | 186 ++++++++++++++++++
 tb/tb_mba_nch.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mba_pkg.sv
// mba_pkg: shared types and helpers for the
// N-channel memory bus arbiter.
package mba_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } mba_state_e;

  localparam logic MBA_FIXED = 1'b0;
  localparam logic MBA_RR    = 1'b1;

  // ceil(log2(v)), never below one bit
  function automatic int mba_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mba_pick.sv
// mba_pick: combinational channel picker,
// fixed priority or round-robin from ptr+1.
module mba_pick
  import mba_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = mba_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic             mode,
  input  logic [IDW-1:0]   ptr,
  input  logic [N_REQ-1:0] excl,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  logic [N_REQ-1:0] cand;

  assign cand  = pending & ~excl;
  assign valid = |cand;

  // later loop iterations overwrite, so the first hit
  // in search order is scanned last
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    if (mode == MBA_FIXED) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (cand[i]) idx = IDW'(i);
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        j = (int'(ptr) + 1 + k) % N_REQ;
        if (cand[j]) idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mba_nch.sv
// mba_nch: N-channel memory bus arbiter with request
// recording, fixed/RR picking, turnaround and hold limit.
module mba_nch
  import mba_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int RR_MODE  = 0,
  parameter  int TURN_MAX = 3,
  parameter  int MAX_HOLD = 16,
  localparam int IDW      = mba_clog2(N_REQ)
) (
  input  logic             clk_166M66,
  input  logic             mcu_sys_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_rw,
  input  logic             i_status_bus_transmitting,
  output logic [N_REQ-1:0] o_allow,
  output logic [IDW-1:0]   o_grant_id,
  output logic             o_data_bus_rw,
  output logic             o_data_bus_enable
);

  localparam int TW = mba_clog2(TURN_MAX + 1);
  localparam int HW = mba_clog2(MAX_HOLD + 1);

  localparam logic MODE =
    (RR_MODE != 0) ? MBA_RR : MBA_FIXED;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_MAX - 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [IDW-1:0] PTR_RST = IDW'(N_REQ - 1);

  mba_state_e state, state_n;

  logic [N_REQ-1:0] pending, pend_n;
  logic [N_REQ-1:0] req_q;
  logic [IDW-1:0]   last_owner, last_n;
  logic [IDW-1:0]   gid_n;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [TW-1:0]    turn_cnt, turn_n;
  logic             hexcl, hexcl_n;
  logic [N_REQ-1:0] allow_n;
  logic             rw_n;
  logic             en_n;

  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] excl;
  logic             others;
  logic             lower;
  logic             rel;
  logic             dirchg;
  logic             preempt;
  logic             hold_hit;
  logic             pick_v;
  logic [IDW-1:0]   pick_idx;

  always_comb begin
    own_oh = ONE << o_grant_id;
    others = |(pending & ~own_oh);
    lower  = |(pending & (own_oh - ONE));
    // a hold-limited owner sits out one pick if others wait
    excl   = (state == TURN && hexcl && others)
             ? own_oh : '0;
  end

  mba_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .pending (pending),
    .mode    (MODE),
    .ptr     (last_owner),
    .excl    (excl),
    .valid   (pick_v),
    .idx     (pick_idx)
  );

  always_comb begin
    rel      = !i_req[o_grant_id];
    dirchg   = i_rw[o_grant_id] != o_data_bus_rw;
    preempt  = (MODE == MBA_FIXED) && lower;
    hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  end

  always_comb begin
    state_n = state;
    pend_n  = pending | (i_req & req_q);
    gid_n   = o_grant_id;
    last_n  = last_owner;
    rw_n    = o_data_bus_rw;
    allow_n = o_allow;
    en_n    = o_data_bus_enable;
    hold_n  = hold_cnt;
    turn_n  = turn_cnt;
    hexcl_n = hexcl;
    unique case (state)
      IDLE: begin
        allow_n = '0;
        en_n    = 1'b0;
        if (pick_v) begin
          state_n = GRANT;
          gid_n   = pick_idx;
          last_n  = pick_idx;
          rw_n    = i_rw[pick_idx];
          allow_n = ONE << pick_idx;
          en_n    = 1'b1;
          hold_n  = '0;
        end
      end
      GRANT: begin
        if (rel) pend_n[o_grant_id] = 1'b0;
        if (rel || dirchg || preempt || hold_hit) begin
          state_n = TURN;
          allow_n = '0;
          en_n    = 1'b0;
          turn_n  = '0;
          hold_n  = '0;
          hexcl_n = hold_hit;
        end else begin
          hold_n = others ? hold_cnt + HW'(1) : '0;
        end
      end
      TURN: begin
        allow_n = '0;
        en_n    = 1'b0;
        if (!i_status_bus_transmitting ||
            turn_cnt == TURN_LAST) begin
          turn_n  = '0;
          hexcl_n = 1'b0;
          if (pick_v) begin
            state_n = GRANT;
            gid_n   = pick_idx;
            last_n  = pick_idx;
            rw_n    = i_rw[pick_idx];
            allow_n = ONE << pick_idx;
            en_n    = 1'b1;
            hold_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          turn_n = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gid_n   = '0;
        last_n  = PTR_RST;
        rw_n    = 1'b0;
        allow_n = '0;
        en_n    = 1'b0;
        hold_n  = '0;
        turn_n  = '0;
        hexcl_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state             <= IDLE;
      pending           <= '0;
      req_q             <= '0;
      last_owner        <= PTR_RST;
      hold_cnt          <= '0;
      turn_cnt          <= '0;
      hexcl             <= 1'b0;
      o_allow           <= '0;
      o_grant_id        <= '0;
      o_data_bus_rw     <= 1'b0;
      o_data_bus_enable <= 1'b0;
    end else begin
      state             <= state_n;
      pending           <= pend_n;
      req_q             <= i_req;
      last_owner        <= last_n;
      hold_cnt          <= hold_n;
      turn_cnt          <= turn_n;
      hexcl             <= hexcl_n;
      o_allow           <= allow_n;
      o_grant_id        <= gid_n;
      o_data_bus_rw     <= rw_n;
      o_data_bus_enable <= en_n;
    end
  end

endmodule

// File: tb/tb_mba_nch.sv
// tb_mba_nch: directed bench, one fixed-priority and
// one round-robin arbiter on a shared clock and reset.
module tb_mba_nch;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] f_req, f_rw;
  logic       f_tx;
  logic [3:0] f_allow;
  logic [1:0] f_gid;
  logic       f_rwo, f_en;

  logic [3:0] r_req, r_rw;
  logic       r_tx;
  logic [3:0] r_allow;
  logic [1:0] r_gid;
  logic       r_rwo, r_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mba_nch #(
    .N_REQ    (4),
    .RR_MODE  (0),
    .TURN_MAX (3),
    .MAX_HOLD (16)
  ) u_fix (
    .clk_166M66                (clk),
    .mcu_sys_rst_n             (rst_n),
    .i_req                     (f_req),
    .i_rw                      (f_rw),
    .i_status_bus_transmitting (f_tx),
    .o_allow                   (f_allow),
    .o_grant_id                (f_gid),
    .o_data_bus_rw             (f_rwo),
    .o_data_bus_enable         (f_en)
  );

  mba_nch #(
    .N_REQ    (4),
    .RR_MODE  (1),
    .TURN_MAX (3),
    .MAX_HOLD (4)
  ) u_rr (
    .clk_166M66                (clk),
    .mcu_sys_rst_n             (rst_n),
    .i_req                     (r_req),
    .i_rw                      (r_rw),
    .i_status_bus_transmitting (r_tx),
    .o_allow                   (r_allow),
    .o_grant_id                (r_gid),
    .o_data_bus_rw             (r_rwo),
    .o_data_bus_enable         (r_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp_oh;

  initial begin
    rst_n = 1'b0;
    f_req = '0; f_rw = '0; f_tx = 1'b0;
    r_req = '0; r_rw = '0; r_tx = 1'b0;
    tick();
    tick();
    chk("rst_allow", f_allow, 4'b0000);
    chk("rst_gid", f_gid, 2'd0);
    chk("rst_rw", f_rwo, 1'b0);
    chk("rst_en", f_en, 1'b0);
    chk("rst_rr_allow", r_allow, 4'b0000);
    rst_n = 1'b1;

    // single-cycle grant for a dropped request
    f_req = 4'b0100;
    tick();
    chk("t1_k", f_allow, 4'b0000);
    tick();
    chk("t1_k1", f_allow, 4'b0000);
    f_req = 4'b0000;
    tick();
    chk("t1_grant", f_allow, 4'b0100);
    chk("t1_en", f_en, 1'b1);
    chk("t1_gid", f_gid, 2'd2);
    tick();
    chk("t1_turn", f_allow, 4'b0000);
    chk("t1_turn_en", f_en, 1'b0);
    tick();
    chk("t1_idle", f_allow, 4'b0000);
    chk("t1_idle_gid", f_gid, 2'd2);
    tick();
    chk("t1_idle2", f_en, 1'b0);

    // direction change re-grants the same owner
    f_req = 4'b0010;
    tick();
    tick();
    tick();
    chk("t4_grant", f_allow, 4'b0010);
    chk("t4_rw0", f_rwo, 1'b0);
    f_rw = 4'b0010;
    tick();
    chk("t4_turn_en", f_en, 1'b0);
    chk("t4_turn_rw", f_rwo, 1'b0);
    tick();
    chk("t4_regrant", f_allow, 4'b0010);
    chk("t4_rw1", f_rwo, 1'b1);
    tick();
    chk("t4_stay", f_allow, 4'b0010);
    f_req = 4'b0000;
    tick();
    chk("t4_rel", f_allow, 4'b0000);
    tick();
    chk("t4_idle", f_en, 1'b0);

    // preemption by channel 0, then channel 3 resumes
    f_rw  = 4'b0000;
    f_req = 4'b1000;
    tick();
    tick();
    tick();
    chk("t2_own3", f_allow, 4'b1000);
    chk("t2_rw", f_rwo, 1'b0);
    f_req = 4'b1001;
    tick();
    chk("t2_a", f_allow, 4'b1000);
    tick();
    chk("t2_b", f_allow, 4'b1000);
    tick();
    chk("t2_pre", f_allow, 4'b0000);
    chk("t2_pre_en", f_en, 1'b0);
    tick();
    chk("t2_own0", f_allow, 4'b0001);
    chk("t2_gid0", f_gid, 2'd0);
    tick();
    chk("t2_keep0", f_allow, 4'b0001);
    f_req = 4'b1000;
    tick();
    chk("t2_rel0", f_allow, 4'b0000);
    tick();
    chk("t2_back3", f_allow, 4'b1000);
    chk("t2_gid3", f_gid, 2'd3);

    // bus stuck transmitting: full TURN_MAX turnaround
    f_tx = 1'b1;
    f_rw = 4'b1000;
    tick();
    chk("t5_turn0", f_allow, 4'b0000);
    tick();
    chk("t5_turn1", f_en, 1'b0);
    tick();
    chk("t5_turn2", f_en, 1'b0);
    tick();
    chk("t5_grant", f_allow, 4'b1000);
    chk("t5_rw", f_rwo, 1'b1);
    f_tx = 1'b0;

    // asynchronous reset in the middle of a grant
    rst_n = 1'b0;
    #1;
    chk("t6_allow", f_allow, 4'b0000);
    chk("t6_en", f_en, 1'b0);
    chk("t6_rw", f_rwo, 1'b0);
    chk("t6_gid", f_gid, 2'd0);
    tick();
    chk("t6_hold", f_allow, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("t6_k", f_allow, 4'b0000);
    tick();
    chk("t6_k1", f_allow, 4'b0000);
    tick();
    chk("t6_grant", f_allow, 4'b1000);
    chk("t6_rw1", f_rwo, 1'b1);
    f_req = 4'b0000;

    // round robin with hold limit 4
    r_req = 4'b1111;
    tick();
    chk("t3_k", r_allow, 4'b0000);
    tick();
    chk("t3_k1", r_allow, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << order[g];
      for (int c = 0; c < 5; c++) begin
        tick();
        chk($sformatf("t3_g%0d_c%0d", g, c),
            r_allow, exp_oh);
      end
      tick();
      chk($sformatf("t3_turn%0d", g), r_allow, 4'b0000);
      chk($sformatf("t3_turn_en%0d", g), r_en, 1'b0);
    end
    r_req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
